chopper_timers: RTL and testbench
=================================

# chopper_timers

Fixed-off-time chopper timing stage feeding `microstepper_control`. For each of the two bridge channels (0 = phase A, 1 = phase B) it holds the off, blanking and minimum-on timers. The timers are started by the control block's `offtimer_en0/1` requests and restarted on commutation (step-pattern change). Its outputs drive `off_timer0/1`, `blank_timer0/1` and `minimum_on_timer0/1` of `microstepper_control` directly, closing the peak-current loop.

## Interface
Parameters:
- `OFF_W`, 10: off-timer width.
- `BLANK_W`, 8: blank-timer width.
- `MINON_W`, 8: minimum-on-timer width.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock.
- `resetn`  in  1: asynchronous active-low reset.
- `enable`  in  1: driver enable; low holds all timers at 0.
- `offtimer_en0`, `offtimer_en1`  in  1: off-time start request per channel.
- `s1`, `s2`, `s3`, `s4`  in  1: bridge step pattern; `s1`/`s2` belong to channel 0, `s3`/`s4` to channel 1.
- `config_offtime`  in  OFF_W: off-time reload value.
- `config_blanktime`  in  BLANK_W: blanking reload value.
- `config_minimum_on_time`  in  MINON_W: minimum-on reload value.
- `off_timer0`, `off_timer1`  out  OFF_W: remaining off time.
- `blank_timer0`, `blank_timer1`  out  BLANK_W: remaining blanking time.
- `minimum_on_timer0`, `minimum_on_timer1`  out  MINON_W: remaining minimum-on time.

## Operation
Each channel runs an independent 3-state FSM: ON, OFF, BLANK. The state is derivable from the timers but is held explicitly.

Reset:
- All timers are 0.
- FSM is in ON.
- Stored step pair is 2'b00.

Commutation:
- Defined as the channel's step pair differing from its value registered on the previous clk.
- Action: load blank and minimum-on timers from config, clear the off timer, go to BLANK.
- Commutation has priority over every other event in that cycle.

ON state:
- `offtimer_en` high loads the off timer with `config_offtime` and the FSM goes to OFF.
- If `config_offtime` == 0, the load writes 0 and the FSM stays in ON.

OFF state:
- The off timer decrements once per tick.
- On the tick where it goes 1→0, load blank and minimum-on timers and go to BLANK.
- `offtimer_en` is ignored while in OFF.

BLANK state:
- The blank timer decrements once per tick; when it reaches 0 the FSM goes to ON.
- If `config_blanktime` == 0, the FSM passes straight to ON on the next clk.

Minimum-on timer:
- Decrements once per tick in any state and saturates at 0.
- A reload while it is nonzero overwrites it.

All decrements saturate at 0; no timer ever wraps.

`enable` low:
- All timers are forced to 0 and the FSM to ON.
- The step pair keeps being registered, so re-enabling does not produce a spurious commutation.

Config inputs are sampled only at load time. Changing them mid-count does not affect running timers.

## Timing
- All outputs are registered.
- Load latency: a request or commutation present before edge N makes the loaded value visible after edge N.
- A "tick" is every clk, unless the prescaler feature is compiled in (see Configuration).
- Off period: with `config_offtime` = T, the off timer is nonzero for exactly T ticks.
- Blanking starts in the same edge in which the off timer reaches 0, so `blank_timer` is nonzero the cycle after `off_timer` reads 1.
- No combinational path exists from any input to any output.
- An asynchronous reset mid-count clears everything immediately. The first load is possible on the first edge after `resetn` deasserts.

## Configuration
Macro: `CHOPPER_PRESCALER_EN`.

Defined:
- Adds input `config_prescale` [7:0] and a shared 8-bit divider.
- A tick occurs once every `config_prescale`+1 clks, so 0 means every clk.
- Loads, commutation and `enable` still act on every clk.
- The divider resets to 0 and restarts whenever `config_prescale` changes.

Undefined:
- The port is absent and every clk is a tick.

## Structure
Shared package `chopper_pkg`:
- Width constants `OFF_W`, `BLANK_W`, `MINON_W`.
- FSM state typedef/localparams: ST_ON, ST_OFF, ST_BLANK.

Sub-module `chopper_channel` holds one FSM plus its three timers and commutation detector; it is instantiated twice. The top level contains the optional prescaler and the port mapping.

## Test plan
- Reset, `config_offtime`=5, `config_blanktime`=3, `offtimer_en0` pulse → `off_timer0` reads 5,4,3,2,1,0, then `blank_timer0` reads 3,2,1,0; channel 1 stays all 0.
- Toggle `s1` while `off_timer0`=3 → next cycle `off_timer0`=0, `blank_timer0`=`config_blanktime`, `minimum_on_timer0`=`config_minimum_on_time`.
- `offtimer_en1` and an `s3` change in the same cycle → commutation wins: `off_timer1`=0, `blank_timer1` loaded.
- `config_offtime`=0 with `offtimer_en0` held high → `off_timer0` stays 0 and the FSM stays in ON.
- Drop `enable` mid-count, raise it two cycles later with `s1..s4` unchanged → all timers 0, no blank load after re-enable.
- With `CHOPPER_PRESCALER_EN` and `config_prescale`=3, `config_offtime`=2 → `off_timer0` holds each value for 4 clks and reaches 0 after 8 clks.

Source files
------------

// File: rtl/chopper_pkg.sv
// Shared widths and channel state encoding for the chopper timing stage.
package chopper_pkg;

   localparam int OFF_W   = 10;
   localparam int BLANK_W = 8;
   localparam int MINON_W = 8;

   typedef enum logic [1:0] {
      ST_ON    = 2'd0,
      ST_OFF   = 2'd1,
      ST_BLANK = 2'd2
   } chop_state_e;

endpackage

// File: rtl/chopper_timers_if.sv
// Control/config/timer bundle between microstepper_control and chopper_timers.
// Carries config_prescale only when CHOPPER_PRESCALER_EN is defined.
interface chopper_timers_if #(
   parameter int OFF_W   = chopper_pkg::OFF_W,
   parameter int BLANK_W = chopper_pkg::BLANK_W,
   parameter int MINON_W = chopper_pkg::MINON_W
);
   logic               enable;
   logic               offtimer_en0;
   logic               offtimer_en1;
   logic               s1;
   logic               s2;
   logic               s3;
   logic               s4;
   logic [OFF_W-1:0]   config_offtime;
   logic [BLANK_W-1:0] config_blanktime;
   logic [MINON_W-1:0] config_minimum_on_time;
`ifdef CHOPPER_PRESCALER_EN
   logic [7:0]         config_prescale;
`endif
   logic [OFF_W-1:0]   off_timer0;
   logic [OFF_W-1:0]   off_timer1;
   logic [BLANK_W-1:0] blank_timer0;
   logic [BLANK_W-1:0] blank_timer1;
   logic [MINON_W-1:0] minimum_on_timer0;
   logic [MINON_W-1:0] minimum_on_timer1;

   modport master (
      output enable, offtimer_en0, offtimer_en1, s1, s2, s3, s4,
             config_offtime, config_blanktime, config_minimum_on_time,
`ifdef CHOPPER_PRESCALER_EN
             config_prescale,
`endif
      input  off_timer0, off_timer1, blank_timer0, blank_timer1,
             minimum_on_timer0, minimum_on_timer1
   );

   modport slave (
      input  enable, offtimer_en0, offtimer_en1, s1, s2, s3, s4,
             config_offtime, config_blanktime, config_minimum_on_time,
`ifdef CHOPPER_PRESCALER_EN
             config_prescale,
`endif
      output off_timer0, off_timer1, blank_timer0, blank_timer1,
             minimum_on_timer0, minimum_on_timer1
   );

endinterface

// File: rtl/chopper_channel.sv
// One bridge channel: ON/OFF/BLANK FSM, off/blank/minimum-on timers and
// commutation detection on the channel's step pair.
module chopper_channel
   import chopper_pkg::*;
#(
   parameter int OffW   = OFF_W,
   parameter int BlankW = BLANK_W,
   parameter int MinOnW = MINON_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable_i,
   input  logic              tick_i,
   input  logic              offEn_i,
   input  logic [1:0]        step_i,
   input  logic [OffW-1:0]   cfgOff_i,
   input  logic [BlankW-1:0] cfgBlank_i,
   input  logic [MinOnW-1:0] cfgMinOn_i,
   output logic [OffW-1:0]   offTimer_o,
   output logic [BlankW-1:0] blankTimer_o,
   output logic [MinOnW-1:0] minOnTimer_o
);

   chop_state_e       state_q, state_d;
   logic [1:0]        step_q, step_d;
   logic [OffW-1:0]   off_q, off_d;
   logic [BlankW-1:0] blank_q, blank_d;
   logic [MinOnW-1:0] minOn_q, minOn_d;
   logic              commutation;

   assign commutation = (step_i != step_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_ON;
         step_q  <= 2'b00;
         off_q   <= '0;
         blank_q <= '0;
         minOn_q <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         off_q   <= off_d;
         blank_q <= blank_d;
         minOn_q <= minOn_d;
      end
   end

   // The step pair is tracked even while disabled so re-enabling cannot
   // look like a commutation.
   always_comb begin
      state_d = state_q;
      step_d  = step_i;
      off_d   = off_q;
      blank_d = blank_q;
      minOn_d = minOn_q;

      if (!enable_i) begin
         state_d = ST_ON;
         off_d   = '0;
         blank_d = '0;
         minOn_d = '0;
      end else if (commutation) begin
         state_d = ST_BLANK;
         off_d   = '0;
         blank_d = cfgBlank_i;
         minOn_d = cfgMinOn_i;
      end else begin
         if (tick_i && (minOn_q != '0)) begin
            minOn_d = minOn_q - MinOnW'(1);
         end
         unique case (state_q)
            ST_ON: begin
               if (offEn_i) begin
                  off_d = cfgOff_i;
                  if (cfgOff_i != '0) begin
                     state_d = ST_OFF;
                  end
               end
            end
            ST_OFF: begin
               if (tick_i) begin
                  if (off_q > OffW'(1)) begin
                     off_d = off_q - OffW'(1);
                  end else begin
                     off_d   = '0;
                     blank_d = cfgBlank_i;
                     minOn_d = cfgMinOn_i;
                     state_d = ST_BLANK;
                  end
               end
            end
            ST_BLANK: begin
               // A zero blanking reload falls straight through to ON.
               if (blank_q == '0) begin
                  state_d = ST_ON;
               end else if (tick_i) begin
                  blank_d = blank_q - BlankW'(1);
                  if (blank_q == BlankW'(1)) begin
                     state_d = ST_ON;
                  end
               end
            end
            default: state_d = ST_ON;
         endcase
      end
   end

   assign offTimer_o   = off_q;
   assign blankTimer_o = blank_q;
   assign minOnTimer_o = minOn_q;

endmodule

// File: rtl/chopper_timers.sv
// Two-channel fixed-off-time chopper timing stage with optional shared tick
// prescaler (enabled by defining CHOPPER_PRESCALER_EN).
module chopper_timers #(
   parameter int OFF_W   = chopper_pkg::OFF_W,
   parameter int BLANK_W = chopper_pkg::BLANK_W,
   parameter int MINON_W = chopper_pkg::MINON_W
) (
   input logic             clk,
   input logic             resetn,
   chopper_timers_if.slave bus
);

   logic tick;

`ifdef CHOPPER_PRESCALER_EN
   logic [7:0] div_q, div_d;
   logic [7:0] prescale_q;
   logic       prescaleChanged;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q      <= '0;
         prescale_q <= '0;
      end else begin
         div_q      <= div_d;
         prescale_q <= bus.config_prescale;
      end
   end

   // A new divide ratio restarts the count from zero without ticking.
   always_comb begin
      prescaleChanged = (bus.config_prescale != prescale_q);
      tick            = !prescaleChanged && (div_q == bus.config_prescale);
      div_d           = div_q + 8'd1;
      if (prescaleChanged || tick) begin
         div_d = '0;
      end
   end
`else
   assign tick = 1'b1;
`endif

   chopper_channel #(
      .OffW   (OFF_W),
      .BlankW (BLANK_W),
      .MinOnW (MINON_W)
   ) u_ch0 (
      .clk          (clk),
      .resetn       (resetn),
      .enable_i     (bus.enable),
      .tick_i       (tick),
      .offEn_i      (bus.offtimer_en0),
      .step_i       ({bus.s1, bus.s2}),
      .cfgOff_i     (bus.config_offtime),
      .cfgBlank_i   (bus.config_blanktime),
      .cfgMinOn_i   (bus.config_minimum_on_time),
      .offTimer_o   (bus.off_timer0),
      .blankTimer_o (bus.blank_timer0),
      .minOnTimer_o (bus.minimum_on_timer0)
   );

   chopper_channel #(
      .OffW   (OFF_W),
      .BlankW (BLANK_W),
      .MinOnW (MINON_W)
   ) u_ch1 (
      .clk          (clk),
      .resetn       (resetn),
      .enable_i     (bus.enable),
      .tick_i       (tick),
      .offEn_i      (bus.offtimer_en1),
      .step_i       ({bus.s3, bus.s4}),
      .cfgOff_i     (bus.config_offtime),
      .cfgBlank_i   (bus.config_blanktime),
      .cfgMinOn_i   (bus.config_minimum_on_time),
      .offTimer_o   (bus.off_timer1),
      .blankTimer_o (bus.blank_timer1),
      .minOnTimer_o (bus.minimum_on_timer1)
   );

endmodule

// File: tb/tb_chopper_timers.sv
// Directed testbench for chopper_timers; inputs change and outputs are
// sampled on the falling clock edge.
module tb_chopper_timers;

   logic clk = 1'b0;
   logic resetn;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   chopper_timers_if bus ();

   chopper_timers dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      waitCycles(2);
      vectors++;
      if (bus.off_timer0 !== 10'd0) begin
         miscompares++;
         $display("[TB] FAIL reset off_timer0: got %0d, expected 0", bus.off_timer0);
      end
      vectors++;
      if (bus.off_timer1 !== 10'd0) begin
         miscompares++;
         $display("[TB] FAIL reset off_timer1: got %0d, expected 0", bus.off_timer1);
      end
      vectors++;
      if (bus.blank_timer0 !== 8'd0 || bus.blank_timer1 !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL reset blank_timers: got %0d/%0d, expected 0/0",
                  bus.blank_timer0, bus.blank_timer1);
      end
      vectors++;
      if (bus.minimum_on_timer0 !== 8'd0 || bus.minimum_on_timer1 !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL reset minon_timers: got %0d/%0d, expected 0/0",
                  bus.minimum_on_timer0, bus.minimum_on_timer1);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_off_cycle;
      int expOff [9];
      int expBlank [9];
      int expMinOn [9];
      expOff   = '{5, 4, 3, 2, 1, 0, 0, 0, 0};
      expBlank = '{0, 0, 0, 0, 0, 3, 2, 1, 0};
      expMinOn = '{0, 0, 0, 0, 0, 4, 3, 2, 1};
      bus.offtimer_en0 = 1'b1;
      @(negedge clk);
      bus.offtimer_en0 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         vectors++;
         if (bus.off_timer0 !== expOff[i][9:0] || bus.blank_timer0 !== expBlank[i][7:0] ||
             bus.minimum_on_timer0 !== expMinOn[i][7:0]) begin
            miscompares++;
            $display("[TB] FAIL offCycle step %0d: got off=%0d blank=%0d minon=%0d, expected off=%0d blank=%0d minon=%0d",
                     i, bus.off_timer0, bus.blank_timer0, bus.minimum_on_timer0,
                     expOff[i], expBlank[i], expMinOn[i]);
         end
      end
      vectors++;
      if (bus.off_timer1 !== 10'd0 || bus.blank_timer1 !== 8'd0 || bus.minimum_on_timer1 !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL offCycle ch1Idle: got off=%0d blank=%0d minon=%0d, expected all 0",
                  bus.off_timer1, bus.blank_timer1, bus.minimum_on_timer1);
      end
   endtask

   task automatic test_commutation;
      bus.config_blanktime       = 8'd6;
      bus.config_minimum_on_time = 8'd9;
      bus.offtimer_en0 = 1'b1;
      @(negedge clk);
      bus.offtimer_en0 = 1'b0;
      waitCycles(2);
      vectors++;
      if (bus.off_timer0 !== 10'd3) begin
         miscompares++;
         $display("[TB] FAIL commutation preOff: got %0d, expected 3", bus.off_timer0);
      end
      bus.s1 = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.off_timer0 !== 10'd0 || bus.blank_timer0 !== 8'd6 || bus.minimum_on_timer0 !== 8'd9) begin
         miscompares++;
         $display("[TB] FAIL commutation reload: got off=%0d blank=%0d minon=%0d, expected off=0 blank=6 minon=9",
                  bus.off_timer0, bus.blank_timer0, bus.minimum_on_timer0);
      end
      waitCycles(12);
   endtask

   task automatic test_back_to_back;
      bus.offtimer_en1 = 1'b1;
      bus.s3 = 1'b1;
      @(negedge clk);
      bus.offtimer_en1 = 1'b0;
      vectors++;
      if (bus.off_timer1 !== 10'd0 || bus.blank_timer1 !== 8'd6 || bus.minimum_on_timer1 !== 8'd9) begin
         miscompares++;
         $display("[TB] FAIL priority ch1: got off=%0d blank=%0d minon=%0d, expected off=0 blank=6 minon=9",
                  bus.off_timer1, bus.blank_timer1, bus.minimum_on_timer1);
      end
      vectors++;
      if (bus.off_timer0 !== 10'd0 || bus.blank_timer0 !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL priority ch0Quiet: got off=%0d blank=%0d, expected 0/0",
                  bus.off_timer0, bus.blank_timer0);
      end
      waitCycles(12);
   endtask

   task automatic test_zero_offtime;
      bus.config_offtime = 10'd0;
      bus.offtimer_en0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.off_timer0 !== 10'd0 || bus.blank_timer0 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL zeroOff hold %0d: got off=%0d blank=%0d, expected 0/0",
                     i, bus.off_timer0, bus.blank_timer0);
         end
      end
      bus.config_offtime = 10'd4;
      @(negedge clk);
      bus.offtimer_en0 = 1'b0;
      vectors++;
      if (bus.off_timer0 !== 10'd4 || bus.blank_timer0 !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL zeroOff stillOn: got off=%0d blank=%0d, expected off=4 blank=0",
                  bus.off_timer0, bus.blank_timer0);
      end
      waitCycles(14);
   endtask

   task automatic test_enable;
      bus.config_offtime = 10'd5;
      bus.offtimer_en0 = 1'b1;
      @(negedge clk);
      bus.offtimer_en0 = 1'b0;
      vectors++;
      if (bus.off_timer0 !== 10'd5) begin
         miscompares++;
         $display("[TB] FAIL enable load: got %0d, expected 5", bus.off_timer0);
      end
      @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.off_timer0 !== 10'd0 || bus.blank_timer0 !== 8'd0 || bus.minimum_on_timer0 !== 8'd0 ||
          bus.off_timer1 !== 10'd0 || bus.blank_timer1 !== 8'd0 || bus.minimum_on_timer1 !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL enable forceZero: got ch0 %0d/%0d/%0d ch1 %0d/%0d/%0d, expected all 0",
                  bus.off_timer0, bus.blank_timer0, bus.minimum_on_timer0,
                  bus.off_timer1, bus.blank_timer1, bus.minimum_on_timer1);
      end
      bus.s2 = ~bus.s2;
      @(negedge clk);
      bus.enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.off_timer0 !== 10'd0 || bus.blank_timer0 !== 8'd0 || bus.minimum_on_timer0 !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL enable noSpurious %0d: got off=%0d blank=%0d minon=%0d, expected all 0",
                     i, bus.off_timer0, bus.blank_timer0, bus.minimum_on_timer0);
         end
      end
   endtask

`ifdef CHOPPER_PRESCALER_EN
   task automatic test_prescaler;
      int expOff [9];
      expOff = '{2, 2, 2, 2, 1, 1, 1, 1, 0};
      bus.config_offtime  = 10'd2;
      bus.config_prescale = 8'd3;
      bus.offtimer_en0    = 1'b1;
      @(negedge clk);
      bus.offtimer_en0 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         vectors++;
         if (bus.off_timer0 !== expOff[i][9:0]) begin
            miscompares++;
            $display("[TB] FAIL prescale step %0d: got %0d, expected %0d", i, bus.off_timer0, expOff[i]);
         end
      end
   endtask
`endif

   initial begin
      bus.enable                 = 1'b1;
      bus.offtimer_en0           = 1'b0;
      bus.offtimer_en1           = 1'b0;
      bus.s1                     = 1'b0;
      bus.s2                     = 1'b0;
      bus.s3                     = 1'b0;
      bus.s4                     = 1'b0;
      bus.config_offtime         = 10'd5;
      bus.config_blanktime       = 8'd3;
      bus.config_minimum_on_time = 8'd4;
`ifdef CHOPPER_PRESCALER_EN
      bus.config_prescale        = 8'd0;
`endif
      test_reset();
      test_off_cycle();
      test_commutation();
      test_back_to_back();
      test_zero_offtime();
      test_enable();
`ifdef CHOPPER_PRESCALER_EN
      test_prescaler();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
